// File: rtl/bootram_ctrl.sv
// Boot RAM controller: arbitrates the PicoRV32 native bus and a sequential
// byte loader onto four 2Kx8 single-port RAM byte lanes.
module bootram_ctrl #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  // CPU side
  input  logic              mem_valid,
  input  logic [ADDR_W+1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  // loader side
  input  logic              ld_req,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic [ADDR_W+2:0] ld_count,
  output logic              ld_overflow,
  // RAM lanes
  output logic [3:0]        ram_ce,
  output logic              ram_oce,
  output logic [3:0]        ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              ram_reset
);
  localparam int CNT_W = ADDR_W + 3;
  // Byte capacity and index of the final byte slot.
  localparam logic [CNT_W-1:0] CAP      = {1'b1, {(ADDR_W+2){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IDX = CAP - 1'b1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP, LOAD} state_e;

  state_e           state_q, state_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ld_acc;

  assign ld_acc      = (state_q == LOAD) && ld_valid;
  assign mem_ready   = (state_q == RESP);
  assign mem_rdata   = rdata_q;
  assign ld_ready    = (state_q == LOAD);
  assign ld_busy     = (state_q == LOAD);
  assign ld_count    = cnt_q;
  assign ld_overflow = ovf_q;
  assign ram_oce     = ~reset;
  assign ram_reset   = reset;

  // State, read data and loader counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state, and RAM lane controls for the issue cycle only.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ram_ce  = 4'b0000;
    ram_wre = 4'b0000;
    ram_ad  = '0;
    ram_din = '0;
    case (state_q)
      IDLE: begin
        // Loader wins; a CPU request seen together with ld_req stays pending.
        if (ld_req) begin
          state_d = LOAD;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (mem_valid) begin
          ram_ad = mem_addr[ADDR_W+1:2];
          if (mem_wstrb == 4'b0000) begin
            ram_ce  = 4'b1111;
            state_d = RD_WAIT;
          end else begin
            ram_ce  = mem_wstrb;
            ram_wre = mem_wstrb;
            ram_din = mem_wdata;
            state_d = RESP;
          end
        end
      end
      RD_WAIT: begin
        rdata_d = ram_dout;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      LOAD: begin
        if (ld_acc) begin
          ram_ad  = cnt_q[ADDR_W+1:2];
          ram_ce  = 4'b0001 << cnt_q[1:0];
          ram_wre = 4'b0001 << cnt_q[1:0];
          ram_din = {4{ld_data}};
          if (cnt_q != CAP) cnt_d = cnt_q + 1'b1;
          if (ld_last) begin
            state_d = IDLE;
          end else if (cnt_q == LAST_IDX) begin
            ovf_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing reaches the RAM while reset is held.
    if (reset) begin
      ram_ce  = 4'b0000;
      ram_wre = 4'b0000;
    end
  end
endmodule

// File: doc/bootram_ctrl.md
# bootram_ctrl

Controller that drives the four 2Kx8 single-port boot RAM byte lanes from two initiators. The CPU side is the PicoRV32 native memory interface (32-bit word reads, byte-strobed writes). The loader side is a byte stream (valid/ready) that fills the RAM sequentially before or between CPU accesses. The block sits between the CPU bus decoder and the boot RAM macros, and owns every lane's ce/oce/wre/ad/din.

## Interface
- ADDR_W, 11, word-address width per lane (2^ADDR_W words, 4·2^ADDR_W bytes total)
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; also driven to ram_reset
- mem_valid  in  1  CPU request
- mem_addr  in  ADDR_W+2  CPU byte address; bits [1:0] ignored, higher CPU bits not routed here
- mem_wdata  in  32  write data, lane i = bits [8i+7:8i]
- mem_wstrb  in  4  byte strobes; 0000 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  registered read data, valid while mem_ready=1
- ld_req  in  1  level request to enter load mode
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte
- ld_last  in  1  marks final byte, qualified by ld_valid
- ld_ready  out  1  loader byte accepted when ld_valid & ld_ready
- ld_busy  out  1  high while in LOAD
- ld_count  out  ADDR_W+3  bytes written by current/last load
- ld_overflow  out  1  sticky: load hit capacity without ld_last
- ram_ce  out  4  per-lane chip enable
- ram_oce  out  1  output clock enable, constant 1 when not in reset
- ram_wre  out  4  per-lane write enable
- ram_ad  out  ADDR_W  shared word address
- ram_din  out  32  lane write data
- ram_dout  in  32  lane read data (RAM in bypass read mode: valid one cycle after ce)
- ram_reset  out  1  = reset

## Operation
- States: IDLE, RD_WAIT, RESP, LOAD.
- IDLE priority: ld_req over mem_valid. ld_req=1 -> LOAD, ld_count cleared, ld_overflow cleared. Otherwise mem_valid=1 -> access issued this cycle.
- Read (wstrb=0000): in IDLE, ram_ce=1111, ram_wre=0000, ram_ad=mem_addr[ADDR_W+1:2]; -> RD_WAIT. RD_WAIT: mem_rdata <= ram_dout; -> RESP.
- Write: in IDLE, ram_ce=ram_wre=mem_wstrb, ram_din=mem_wdata; -> RESP. Unstrobed lanes untouched.
- RESP: mem_ready=1 for exactly one cycle; -> IDLE. The CPU drops mem_valid after the ready edge, so IDLE never re-accepts the same request.
- LOAD: ld_ready=1. On each ld_valid&ld_ready, byte n=ld_count is written to lane n[1:0] at word n[ADDR_W+1:2], ram_ce=ram_wre=one-hot lane, ram_din all lanes = ld_data. Then ld_count increments. Little-endian: byte 0 -> bits [7:0] of word 0.
- LOAD exit: the accepted byte with ld_last=1 -> IDLE. Accepted byte number 4·2^ADDR_W−1 without ld_last -> ld_overflow=1, -> IDLE; further bytes are not accepted (ld_ready=0 outside LOAD). ld_count saturates at 4·2^ADDR_W.
- ld_req deasserting mid-load has no effect; only ld_last or capacity ends LOAD. ld_req still high at return to IDLE starts a new load.
- mem_valid during LOAD: stalled, mem_ready low; served from IDLE after LOAD ends.
- ld_valid gaps: no RAM enables asserted.

## Timing
- Reset values: state IDLE, mem_ready 0, mem_rdata 0, ld_ready 0, ld_busy 0, ld_count 0, ld_overflow 0, ram_ce 0, ram_wre 0, ram_ad 0, ram_din 0, ram_oce 0.
- Read: mem_valid sampled in IDLE at edge T; mem_ready high in cycle T+2; 3 cycles per read.
- Write: mem_ready in cycle T+1; 2 cycles per write.
- Load: one byte per cycle sustained; ld_busy high from the cycle after ld_req is sampled through the cycle of the ld_last transfer.
- RAM control outputs are combinational from state and registered counters. No RAM enable is asserted outside the issue cycle.
- Reset mid-operation: immediate return to reset values. A pending CPU access is dropped, and a load is aborted with ld_count=0. RAM contents already written are retained.

## Test plan
- Load 8 bytes 0x11..0x88, ld_last on 8th -> ld_count=8, ld_busy falls. Read addr 0x0 -> 0x44332211, read addr 0x4 -> 0x88776655, each mem_ready at T+2.
- After the above, write addr 0x0, data 0xAABBCCDD, wstrb 0101 -> mem_ready at T+1. Read back 0x44BB22DD.
- ld_req and mem_valid (read 0x4) together in IDLE -> LOAD taken, mem_ready low throughout. Load 4 bytes 0x01..0x04 with last, then read completes returning 0x88776655.
- Load with random ld_valid gaps (50%) of 16 bytes -> only 16 ram_wre pulses, contents match byte order.
- Stream 8192 bytes without ld_last (ADDR_W=11) -> ld_overflow=1, ld_count=8192, ld_ready=0 after. Word 2047 reads the last four bytes.
- Assert reset after 3 loaded bytes -> ld_busy=0, ld_count=0. Subsequent read of addr 0x0 returns the 3 new bytes in the low lanes and the old upper byte.
